// File: rtl/alu_pkg.sv
// Shared datapath ALU definitions: operand widths and the resolved adder mode.
package alu_pkg;

    localparam int DATA_W  = 16;
    localparam int NIB_W   = 4;
    localparam int NUM_NIB = DATA_W / NIB_W;

    typedef enum logic [1:0] {
        ADD  = 2'd0,
        SUB  = 2'd1,
        PADD = 2'd2,
        RED  = 2'd3
    } mode_t;

    // Reduction outranks nibble mode, which outranks subtract.
    function automatic mode_t resolve_mode(input logic sub, input logic padd, input logic red);
        mode_t m;
        if (red)
            m = RED;
        else if (padd)
            m = PADD;
        else if (sub)
            m = SUB;
        else
            m = ADD;
        return m;
    endfunction

endpackage

// File: rtl/adder_16_cla_4bit.sv
// 4-bit carry-lookahead block exporting group propagate/generate for block-level lookahead.
module cla_4bit
    import alu_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] sum,
    output logic             pg,
    output logic             gg,
    output logic             cout
);

    logic [NIB_W-1:0] p;
    logic [NIB_W-1:0] g;
    logic [NIB_W-1:0] c;

    assign p = a ^ b;
    assign g = a & b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

    assign pg = &p;
    assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);

    assign sum  = p ^ c;
    assign cout = gg | (pg & cin);

endmodule

// File: rtl/adder_16.sv
// Registered 16-bit CLA add/sub with nibble-parallel and signed byte-reduction modes.
// Optional signed saturation for add/sub/padd when ADDER16_SAT_EN is defined.
module adder_16
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              padd,
    input  logic              sub,
    input  logic              red,
    output logic [DATA_W-1:0] sum,
    output logic              cout
);

    mode_t             mode;
    logic [DATA_W-1:0] b_eff;
    logic              c0;
    logic              c1;
    logic              c2;
    logic              c3;
    logic              pg0, pg1, pg2, pg3;
    logic              gg0, gg1, gg2, gg3;
    logic              co0, co1, co2, co3;
    logic [DATA_W-1:0] cla_sum;
    logic [DATA_W-1:0] red_sum;
    logic [DATA_W-1:0] res_sum;
    logic              res_cout;

    assign mode  = resolve_mode(sub, padd, red);
    assign b_eff = (mode == SUB) ? ~b : b;
    assign c0    = (mode == SUB);

    // Block-level lookahead; nibble mode isolates every nibble from its neighbour.
    always_comb begin
        c1 = 1'b0;
        c2 = 1'b0;
        c3 = 1'b0;
        if (mode != PADD) begin
            c1 = gg0 | (pg0 & c0);
            c2 = gg1 | (pg1 & gg0) | (pg1 & pg0 & c0);
            c3 = gg2 | (pg2 & gg1) | (pg2 & pg1 & gg0) | (pg2 & pg1 & pg0 & c0);
        end
    end

    cla_4bit u_cla0 (
        .a    (a[3:0]),
        .b    (b_eff[3:0]),
        .cin  (c0),
        .sum  (cla_sum[3:0]),
        .pg   (pg0),
        .gg   (gg0),
        .cout (co0)
    );

    cla_4bit u_cla1 (
        .a    (a[7:4]),
        .b    (b_eff[7:4]),
        .cin  (c1),
        .sum  (cla_sum[7:4]),
        .pg   (pg1),
        .gg   (gg1),
        .cout (co1)
    );

    cla_4bit u_cla2 (
        .a    (a[11:8]),
        .b    (b_eff[11:8]),
        .cin  (c2),
        .sum  (cla_sum[11:8]),
        .pg   (pg2),
        .gg   (gg2),
        .cout (co2)
    );

    cla_4bit u_cla3 (
        .a    (a[15:12]),
        .b    (b_eff[15:12]),
        .cin  (c3),
        .sum  (cla_sum[15:12]),
        .pg   (pg3),
        .gg   (gg3),
        .cout (co3)
    );

    // Lower block carry-outs duplicate the lookahead carries and are not needed.
    logic unused_block_carries;
    assign unused_block_carries = co0 ^ co1 ^ co2;

    // Four sign-extended bytes; range -512..508 always fits in 16 bits.
    assign red_sum = {{8{a[15]}}, a[15:8]} + {{8{a[7]}}, a[7:0]}
                   + {{8{b[15]}}, b[15:8]} + {{8{b[7]}}, b[7:0]};

    always_comb begin
        res_sum  = cla_sum;
        res_cout = co3;
        if (mode == RED) begin
            res_sum  = red_sum;
            res_cout = 1'b0;
        end
`ifdef ADDER16_SAT_EN
        else if (mode == PADD) begin
            for (int k = 0; k < NUM_NIB; k++) begin
                if ((a[k*NIB_W+3] == b_eff[k*NIB_W+3]) &&
                    (cla_sum[k*NIB_W+3] != a[k*NIB_W+3]))
                    res_sum[k*NIB_W +: NIB_W] = a[k*NIB_W+3] ? 4'h8 : 4'h7;
            end
        end
        else if ((a[15] == b_eff[15]) && (cla_sum[15] != a[15])) begin
            res_sum = a[15] ? 16'h8000 : 16'h7FFF;
        end
`endif
    end

    // Result and carry are registered; reset clears them immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum  <= '0;
            cout <= 1'b0;
        end else begin
            sum  <= res_sum;
            cout <= res_cout;
        end
    end

endmodule

// File: tb/tb_adder_16.sv
// Directed and randomized nibble-mode testbench for adder_16.
// Expectations follow ADDER16_SAT_EN when the bench is built with it.
module tb_adder_16;

    logic        clk;
    logic        rst;
    logic [15:0] a;
    logic [15:0] b;
    logic        padd;
    logic        sub;
    logic        red;
    logic [15:0] sum;
    logic        cout;

    int n_checks = 0;
    int n_pass   = 0;

    adder_16 dut (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .b    (b),
        .padd (padd),
        .sub  (sub),
        .red  (red),
        .sum  (sum),
        .cout (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive operands between edges, then sample just after the capturing edge.
    task automatic apply_stimulus(input logic [15:0] ta, input logic [15:0] tb,
                                  input logic tpadd, input logic tsub, input logic tred);
        @(negedge clk);
        a    = ta;
        b    = tb;
        padd = tpadd;
        sub  = tsub;
        red  = tred;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        n_checks++;
        if (sum !== 16'h0000) $display("[TB] FAIL reset_sum: got %h expected 0000", sum);
        else n_pass++;
        n_checks++;
        if (cout !== 1'b0) $display("[TB] FAIL reset_cout: got %b expected 0", cout);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_add;
        apply_stimulus(16'h1234, 16'h0FFF, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (sum !== 16'h2233 || cout !== 1'b0)
            $display("[TB] FAIL add_basic: got %h/%b expected 2233/0", sum, cout);
        else n_pass++;
        apply_stimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (sum !== 16'h0000 || cout !== 1'b1)
            $display("[TB] FAIL add_wrap: got %h/%b expected 0000/1", sum, cout);
        else n_pass++;
    endtask

    task automatic test_sub;
        apply_stimulus(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (sum !== 16'hFFFE || cout !== 1'b0)
            $display("[TB] FAIL sub_borrow: got %h/%b expected fffe/0", sum, cout);
        else n_pass++;
        apply_stimulus(16'h0007, 16'h0005, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (sum !== 16'h0002 || cout !== 1'b1)
            $display("[TB] FAIL sub_noborrow: got %h/%b expected 0002/1", sum, cout);
        else n_pass++;
    endtask

    task automatic test_padd;
        logic [15:0] exp_sum;
        apply_stimulus(16'h1234, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (sum !== 16'h0123 || cout !== 1'b1)
            $display("[TB] FAIL padd_sub0: got %h/%b expected 0123/1", sum, cout);
        else n_pass++;
        apply_stimulus(16'h1234, 16'hFFFF, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (sum !== 16'h0123 || cout !== 1'b1)
            $display("[TB] FAIL padd_sub1: got %h/%b expected 0123/1", sum, cout);
        else n_pass++;
`ifdef ADDER16_SAT_EN
        exp_sum = 16'h7777;
`else
        exp_sum = 16'h8888;
`endif
        apply_stimulus(16'h7777, 16'h1111, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (sum !== exp_sum || cout !== 1'b0)
            $display("[TB] FAIL padd_overflow: got %h/%b expected %h/0", sum, cout, exp_sum);
        else n_pass++;
    endtask

    task automatic test_red;
        apply_stimulus(16'h0102, 16'h0304, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (sum !== 16'h000A || cout !== 1'b0)
            $display("[TB] FAIL red_small: got %h/%b expected 000a/0", sum, cout);
        else n_pass++;
        apply_stimulus(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (sum !== 16'hFFFC || cout !== 1'b0)
            $display("[TB] FAIL red_neg: got %h/%b expected fffc/0", sum, cout);
        else n_pass++;
        apply_stimulus(16'h0102, 16'h0304, 1'b1, 1'b1, 1'b1);
        n_checks++;
        if (sum !== 16'h000A || cout !== 1'b0)
            $display("[TB] FAIL red_priority: got %h/%b expected 000a/0", sum, cout);
        else n_pass++;
        apply_stimulus(16'h8080, 16'h8080, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (sum !== 16'hFE00 || cout !== 1'b0)
            $display("[TB] FAIL red_min: got %h/%b expected fe00/0", sum, cout);
        else n_pass++;
        apply_stimulus(16'h7F7F, 16'h7F7F, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (sum !== 16'h01FC || cout !== 1'b0)
            $display("[TB] FAIL red_max: got %h/%b expected 01fc/0", sum, cout);
        else n_pass++;
    endtask

    task automatic test_overflow;
        logic [15:0] exp_pos;
        logic [15:0] exp_neg;
`ifdef ADDER16_SAT_EN
        exp_pos = 16'h7FFF;
        exp_neg = 16'h8000;
`else
        exp_pos = 16'h8000;
        exp_neg = 16'h7FFF;
`endif
        apply_stimulus(16'h7000, 16'h1000, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (sum !== exp_pos || cout !== 1'b0)
            $display("[TB] FAIL add_overflow: got %h/%b expected %h/0", sum, cout, exp_pos);
        else n_pass++;
        apply_stimulus(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (sum !== exp_neg || cout !== 1'b1)
            $display("[TB] FAIL sub_overflow: got %h/%b expected %h/1", sum, cout, exp_neg);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        apply_stimulus(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (sum !== 16'h0100 || cout !== 1'b0)
            $display("[TB] FAIL b2b_first: got %h/%b expected 0100/0", sum, cout);
        else n_pass++;
        apply_stimulus(16'h0100, 16'h0100, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (sum !== 16'h0000 || cout !== 1'b1)
            $display("[TB] FAIL b2b_second: got %h/%b expected 0000/1", sum, cout);
        else n_pass++;
        apply_stimulus(16'h0FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (sum !== 16'h1000 || cout !== 1'b0)
            $display("[TB] FAIL b2b_carry_chain: got %h/%b expected 1000/0", sum, cout);
        else n_pass++;
    endtask

    task automatic test_async_reset;
        apply_stimulus(16'h1234, 16'h0FFF, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (sum !== 16'h2233) $display("[TB] FAIL areset_pre: got %h expected 2233", sum);
        else n_pass++;
        #2;
        rst = 1'b1;
        a   = 16'hFFFF;
        b   = 16'h0001;
        #1;
        n_checks++;
        if (sum !== 16'h0000 || cout !== 1'b0)
            $display("[TB] FAIL areset_immediate: got %h/%b expected 0000/0", sum, cout);
        else n_pass++;
        @(posedge clk);
        #1;
        n_checks++;
        if (sum !== 16'h0000 || cout !== 1'b0)
            $display("[TB] FAIL areset_held: got %h/%b expected 0000/0", sum, cout);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        a   = 16'h0007;
        b   = 16'h0005;
        sub = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (sum !== 16'h0002 || cout !== 1'b1)
            $display("[TB] FAIL areset_release: got %h/%b expected 0002/1", sum, cout);
        else n_pass++;
    endtask

    task automatic test_random_padd;
        logic [15:0] ra;
        logic [15:0] rb;
        logic [15:0] exp_sum;
        logic        exp_cout;
        int          na;
        int          nb;
        int          ns;
        for (int i = 0; i < 300; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            exp_cout = 1'b0;
            for (int k = 0; k < 4; k++) begin
                na = int'(ra[k*4 +: 4]);
                nb = int'(rb[k*4 +: 4]);
                ns = na + nb;
                exp_sum[k*4 +: 4] = 4'(ns % 16);
`ifdef ADDER16_SAT_EN
                if (na >= 8) na = na - 16;
                if (nb >= 8) nb = nb - 16;
                if (na + nb > 7)  exp_sum[k*4 +: 4] = 4'h7;
                if (na + nb < -8) exp_sum[k*4 +: 4] = 4'h8;
`endif
                if (k == 3) exp_cout = (ns >= 16);
            end
            apply_stimulus(ra, rb, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
            n_checks++;
            if (sum !== exp_sum || cout !== exp_cout)
                $display("[TB] FAIL padd_random a=%h b=%h: got %h/%b expected %h/%b",
                         ra, rb, sum, cout, exp_sum, exp_cout);
            else n_pass++;
        end
    endtask

    initial begin
        rst  = 1'b1;
        a    = '0;
        b    = '0;
        padd = 1'b0;
        sub  = 1'b0;
        red  = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_add();
        test_sub();
        test_padd();
        test_red();
        test_overflow();
        test_back_to_back();
        test_async_reset();
        test_random_padd();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
